// File: rtl/vga_window_compositor.sv
`default_nettype none
// ============================================================================
// Module   : vga_window_compositor
// Brief    : Reads NUM_WIN side-by-side image windows, aligns RAM data with
//            VGA timing and composites 1-bit RGB with a button-driven reveal.
// Revision : 1.0 - initial release
// ============================================================================
module vga_window_compositor #(
  parameter int IMG_W   = 128,
  parameter int IMG_H   = 128,
  parameter int PIX_W   = 8,
  parameter int NUM_WIN = 2,
  parameter int RD_LAT  = 1,
  localparam int ADDR_W = $clog2(IMG_W) + $clog2(IMG_H)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [10:0]                 hcount,
  input  logic [10:0]                 vcount,
  input  logic                        blank,
  input  logic                        hs_in,
  input  logic                        vs_in,
  input  logic                        btn_start,
  input  logic                        btn_next,
  input  logic                        gen_done,
  input  logic [1:0]                  mode,
  input  logic [PIX_W-1:0]            thr,
  output logic [NUM_WIN*ADDR_W-1:0]   rd_addr,
  input  logic [NUM_WIN*PIX_W-1:0]    rd_data,
  output logic                        start_pulse,
  output logic                        hs,
  output logic                        vs,
  output logic                        R,
  output logic                        G,
  output logic                        B,
  output logic [NUM_WIN-1:0]          led
);

  localparam int c_xw = $clog2(IMG_W);
  localparam int c_yw = $clog2(IMG_H);
  // Wide enough for a window index and for reveal_cnt up to NUM_WIN.
  localparam int c_iw = $clog2(NUM_WIN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_REVEAL = 2'd2
  } state_t;

  typedef struct packed {
    logic            blank;
    logic            hs;
    logic            vs;
    logic            in_win;
    logic [c_iw-1:0] idx;
    logic [c_iw-1:0] rev;
  } vid_t;

  logic [10:0]     w_win_full;
  logic            w_in_win;
  logic [c_iw-1:0] w_win_idx;

  assign w_win_full = hcount >> c_xw;
  assign w_in_win   = (vcount < 11'(IMG_H)) && (w_win_full < 11'(NUM_WIN));
  assign w_win_idx  = w_win_full[c_iw-1:0];

  for (genvar k = 0; k < NUM_WIN; k++) begin : g_addr
    assign rd_addr[k*ADDR_W +: ADDR_W] = (w_in_win && (w_win_full == 11'(k))) ?
                                         {vcount[c_yw-1:0], hcount[c_xw-1:0]} : '0;
  end

  // Bits [1:0] synchronise, bit [2] is the previous value for edge detection.
  logic [2:0] r_bs_sync;
  logic [2:0] r_bn_sync;
  logic       r_start_evt;
  logic       r_next_evt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bs_sync   <= '0;
      r_bn_sync   <= '0;
      r_start_evt <= 1'b0;
      r_next_evt  <= 1'b0;
    end else begin
      r_bs_sync   <= {r_bs_sync[1:0], btn_start};
      r_bn_sync   <= {r_bn_sync[1:0], btn_next};
      r_start_evt <= r_bs_sync[1] & ~r_bs_sync[2];
      r_next_evt  <= r_bn_sync[1] & ~r_bn_sync[2];
    end
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_iw-1:0] r_reveal_cnt;
  logic [c_iw-1:0] w_reveal_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_reveal_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_reveal_cnt <= w_reveal_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_reveal_nxt = r_reveal_cnt;
    start_pulse  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_start_evt) begin
          w_state_nxt = ST_BUSY;
          start_pulse = 1'b1;
        end
      end
      ST_BUSY: begin
        if (gen_done) begin
          w_state_nxt  = ST_REVEAL;
          w_reveal_nxt = c_iw'(1);
        end
      end
      ST_REVEAL: begin
        if (r_next_evt && (r_reveal_cnt < c_iw'(NUM_WIN))) begin
          w_reveal_nxt = r_reveal_cnt + c_iw'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // reveal_cnt travels with the pixel so a change lands RD_LAT+1 cycles later.
  vid_t w_vid_in;
  vid_t r_pipe [RD_LAT];
  vid_t w_last;

  always_comb begin
    w_vid_in.blank  = blank;
    w_vid_in.hs     = hs_in;
    w_vid_in.vs     = vs_in;
    w_vid_in.in_win = w_in_win;
    w_vid_in.idx    = w_win_idx;
    w_vid_in.rev    = r_reveal_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_vid_in;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_last = r_pipe[RD_LAT-1];

  logic [PIX_W-1:0] w_pix;
  logic             w_bit;
  logic             w_show;
  logic             w_colour;

  always_comb begin
    w_pix = '0;
    for (int k = 0; k < NUM_WIN; k++) begin
      if (w_last.idx == c_iw'(k)) w_pix = rd_data[k*PIX_W +: PIX_W];
    end
  end

  always_comb begin
    case (mode)
      2'd1:    w_bit = (w_pix >= thr);
      2'd2:    w_bit = ~w_pix[PIX_W-1];
      default: w_bit = w_pix[PIX_W-1];
    endcase
  end

  assign w_show   = w_last.in_win && (w_last.idx < w_last.rev);
  assign w_colour = w_last.blank ? 1'b0 : (w_show ? w_bit : 1'b1);

  logic [NUM_WIN-1:0] w_led;
  for (genvar i = 0; i < NUM_WIN; i++) begin : g_led
    assign w_led[i] = (c_iw'(i) < r_reveal_cnt);
  end

  logic               r_hs;
  logic               r_vs;
  logic               r_rgb;
  logic [NUM_WIN-1:0] r_led;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_rgb <= 1'b0;
      r_led <= '0;
    end else begin
      r_hs  <= w_last.hs;
      r_vs  <= w_last.vs;
      r_rgb <= w_colour;
      r_led <= w_led;
    end
  end

  assign hs  = r_hs;
  assign vs  = r_vs;
  assign R   = r_rgb;
  assign G   = r_rgb;
  assign B   = r_rgb;
  assign led = r_led;

endmodule
`default_nettype wire
